// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
package serial_adder_pkg;

    // Controller states: waiting, shifting bits through the cell, result ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_adder_state_t;

    // Bit counter width: enough to hold W-1, never narrower than one bit
    function automatic int serial_adder_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell used as the serial datapath
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    // Sum is the three-way parity; carry is the majority of the inputs
    always_comb begin
        sum       = a ^ b ^ carry_in;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
    end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial W-bit adder, LSB first; optional SERIAL_ADDER_OVERFLOW_EN
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic         overflow
`endif
);

    localparam int CW = serial_adder_cnt_width(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    serial_adder_state_t state_q;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                carry_q;
    logic [CW-1:0]       cnt_q;
    logic [W-1:0]        sum_q;
    logic                carry_out_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic                overflow_q;
`endif

    logic                cell_sum;
    logic                cell_carry;
    logic [W-1:0]        sum_d;
    logic                last_bit;

    // One cell handles the current LSB pair plus the running carry
    full_adder u_cell (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .carry_in  (carry_q),
        .sum       (cell_sum),
        .carry_out (cell_carry)
    );

    assign last_bit = (cnt_q == LAST_CNT);

    // New result bit enters at the MSB so the LSB ends up at bit 0 after W shifts
    generate
        if (W == 1) begin : g_sum_single
            always_comb begin
                sum_d = cell_sum;
            end
        end else begin : g_sum_shift
            always_comb begin
                sum_d = {cell_sum, sum_q[W-1:1]};
            end
        end
    endgenerate

    // Controller, operand shifters, carry, counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carry_in;
                        cnt_q   <= '0;
                        state_q <= RUN;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        overflow_q <= 1'b0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= cell_carry;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        carry_out_q <= cell_carry;
                        state_q     <= DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // Carry into the MSB differs from carry out of it
                        overflow_q  <= carry_q ^ cell_carry;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status and results come straight from registers
    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        sum       = sum_q;
        carry_out = carry_out_q;
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (W=8 and W=1)
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8, co8, ov8;
    logic [7:0] sum8;

    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy1, done1, co1, ov1;
    logic [0:0] sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .carry_in  (cin8),
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .carry_out (co8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow  (ov8)
`endif
    );

    serial_adder #(.W(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .carry_in  (cin1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (co1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow  (ov1)
`endif
    );

`ifndef SERIAL_ADDER_OVERFLOW_EN
    assign ov8 = 1'b0;
    assign ov1 = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_co;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition of the operands plus carry-in
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output logic [7:0] s, output logic co, output logic ov);
        int total;
        int sa, sb, ss;
        total = int'(a) + int'(b) + int'(cin);
        s  = total[7:0];
        co = total[8];
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
        ss = sa + sb + int'(cin);
        ov = (ss > 127) || (ss < -128);
    endtask

    // Wait for done on the W=8 instance; n = negedges waited, limit+1 on timeout
    task automatic wait_done8(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (done8) return;
        end
        n = limit + 1;
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] es, input logic eco,
                          input logic eov);
        int m;
        logic busy_seen;
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        busy_seen = busy8;
        wait_done8(30, m);
        chk({name, "_latency"}, 32'(1 + m), 32'd9);
        chk({name, "_busy"}, 32'(busy_seen), 32'd1);
        chk({name, "_sum"}, 32'(sum8), 32'(es));
        chk({name, "_co"}, 32'(co8), 32'(eco));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk({name, "_ov"}, 32'(ov8), 32'(eov));
`endif
        @(negedge clk);
    endtask

    initial begin
        int m;
        logic [7:0] es;
        logic eco, eov;

        vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, exp_sum: 8'h10, exp_co: 1'b0, exp_ov: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp_sum: 8'h00, exp_co: 1'b1, exp_ov: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, exp_sum: 8'h80, exp_co: 1'b0, exp_ov: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp_sum: 8'hFF, exp_co: 1'b1, exp_ov: 1'b0};

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_co", 32'(co8), 32'd0);
        chk("rst_ov", 32'(ov8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_co, vecs[i].exp_ov);
        end

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            logic rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, es, eco, eov);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, es, eco, eov);
        end

        // start held high: back-to-back operations every W+1 cycles
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        wait_done8(30, m);
        chk("held_first", 32'(m), 32'd9);
        chk("held_sum0", 32'(sum8), 32'hFF);
        for (int r = 1; r <= 2; r++) begin
            wait_done8(30, m);
            chk($sformatf("held_gap%0d", r), 32'(m), 32'd9);
            chk($sformatf("held_sum%0d", r), 32'(sum8), 32'hFF);
            chk($sformatf("held_co%0d", r), 32'(co8), 32'd1);
        end
        start8 = 1'b0;
        @(negedge clk);
        chk("held_idle", 32'(done8 | busy8), 32'd0);

        // start during RUN is ignored and operands are not re-sampled
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(30, m);
        chk("ign_latency", 32'(4 + m), 32'd9);
        chk("ign_sum", 32'(sum8), 32'h46);
        chk("ign_co", 32'(co8), 32'd0);
        @(negedge clk);

        // reset mid-operation aborts to IDLE
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_sum", 32'(sum8), 32'd0);
        @(negedge clk);
        chk("abort_stay_idle", 32'(busy8 | done8), 32'd0);
        run_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // W=1: exactly one RUN cycle
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", 32'(busy1), 32'd1);
        chk("w1_done_early", 32'(done1), 32'd0);
        @(negedge clk);
        chk("w1_done", 32'(done1), 32'd1);
        chk("w1_sum", 32'(sum1), 32'd1);
        chk("w1_co", 32'(co1), 32'd1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("w1_ov", 32'(ov1), 32'd0);
`endif
        @(negedge clk);
        chk("w1_idle", 32'(busy1 | done1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial W-bit adder that feeds operand bits, LSB first, through the team's `full_adder` cell and returns the sum through a carry flip-flop. It sits directly upstream of `full_adder`: it supplies `a`, `b` and `carry_in` to the cell each cycle and consumes its `sum` and `carry_out`. Multi-bit addition therefore costs one full-adder cell plus shift registers. Operations start with a one-cycle `start` pulse and complete with a one-cycle `done` pulse.

## Interface
- `W`, default 8: operand and result width; legal range is W ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only when the block is idle or in its done cycle.
- `a` in W: operand A; captured on the accepted `start`.
- `b` in W: operand B; captured on the accepted `start`.
- `carry_in` in 1: initial carry; captured on the accepted `start`.
- `busy` out 1: high while bits are being processed.
- `done` out 1: one-cycle pulse when the result is complete.
- `sum` out W: result register.
- `carry_out` out 1: final carry.
- `overflow` out 1: signed overflow; present only with `SERIAL_ADDER_OVERFLOW_EN`.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DONE when the bit counter reaches W−1.
  - DONE → RUN on `start`; otherwise DONE → IDLE.
- Accept:
  - In IDLE or DONE, `start`=1 loads shift registers A←`a` and B←`b`.
  - It also sets carry←`carry_in` and cnt←0, then enters RUN.
- RUN edge:
  - The cell sees A[0], B[0] and carry.
  - sum ← {cell.sum, sum[W-1:1]}; A and B shift right by 1.
  - carry ← cell.carry_out; cnt ← cnt+1.
- Last RUN edge (cnt==W−1): `carry_out` ← cell.carry_out, and the next state is DONE.
- Outputs:
  - `busy` = (state==RUN).
  - `done` = (state==DONE).
- Result validity:
  - `sum` and `carry_out` are valid from the DONE cycle until the next accepted `start`.
  - During RUN, `sum` shows a partially shifted value that benches must not check.
- `start` in RUN is ignored. Operands and `carry_in` are not re-sampled.
- Counter width is $clog2(W) bits, with a minimum of 1. W=1 gives exactly one RUN cycle.
- Arithmetic is modulo 2^W; the carry out of bit W−1 is reported on `carry_out`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `sum`=0, `carry_out`=0, `overflow`=0. Internal A, B, carry and cnt are all 0.
- `rst` has priority over `start`. Reset asserted during RUN aborts the operation, and the block is IDLE on the following cycle.
- Latency: for `start` accepted at edge 0, `busy` is high after edges 1…W−1 and low after edge W. `done` is high for exactly one cycle after edge W.
- Back-to-back: `start` in the DONE cycle is accepted. `done` drops and `busy` rises on the next edge, so throughput is one operation per W+1 cycles.
- No combinational path exists from inputs to outputs.

## Configuration
- `SERIAL_ADDER_OVERFLOW_EN` defined:
  - The `overflow` port exists.
  - On the last RUN edge, `overflow` ← carry ^ cell.carry_out, i.e. carry into the MSB XOR carry out of it.
  - It holds until the next accepted `start`, which clears it to 0.
- `SERIAL_ADDER_OVERFLOW_EN` undefined: the port and its flip-flop are absent, and the rest of the behaviour is identical.

## Structure
- `serial_adder_pkg`: state enum typedef `serial_adder_state_t` (IDLE, RUN, DONE).
- One sub-module: the existing `full_adder`, instantiated once as the bit-slice datapath.
- Shift registers, counter and FSM are local to `serial_adder`.

## Test plan
- W=8, a=8'h0F, b=8'h01, carry_in=0 → `done` one cycle after edge 8; `sum`=8'h10, `carry_out`=0, `overflow`=0.
- a=8'hFF, b=8'h01, carry_in=0 → `sum`=8'h00, `carry_out`=1, `overflow`=0. Then a=8'h7F, b=8'h01 → `sum`=8'h80, `carry_out`=0, `overflow`=1.
- a=8'hFF, b=8'hFF, carry_in=1 → `sum`=8'hFF, `carry_out`=1. Repeat with `start` held high continuously → operations repeat every 9 cycles with identical results.
- Start a=8'h12, b=8'h34. Pulse `start` with a=8'hAA, b=8'h55 at RUN cycle 3 → second `start` ignored; result is `sum`=8'h46.
- Assert `rst` after RUN edge 4 → next cycle IDLE with `busy`=0, `done`=0, `sum`=0. A following op with a=8'h01, b=8'h02 → `sum`=8'h03.
- W=1, a=1, b=1, carry_in=1 → `done` one cycle after edge 1; `sum`=1, `carry_out`=1.
